lockstep_fault_detector: RTL and testbench
==========================================

LOCKSTEP_FAULT_DETECTOR -- requirements
Module: lockstep_fault_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the compared data width.
REQ-002 SHALL have parameter THRESHOLD, default 3, the number of consecutive mismatching samples that raises the alarm (legal range 1..255).
REQ-003 SHALL have parameter CNT_W, default 8, the width of the total-fault counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, comparison enable; when low no sample is compared.
REQ-007 SHALL have port valid, input, 1, in_a and in_b both carry a sample this cycle.
REQ-008 SHALL have port in_a, input, WIDTH, core A result (the glitch-injected path).
REQ-009 SHALL have port in_b, input, WIDTH, core B result (the golden path).
REQ-010 SHALL have port clear, input, 1, acknowledges and clears the alarm and suspect state.
REQ-011 SHALL have port mismatch, output, 1, registered per-sample mismatch flag.
REQ-012 SHALL have port alarm, output, 1, sticky fault alarm.
REQ-013 SHALL have port fault_count, output, CNT_W, saturating count of all mismatching samples.
REQ-014 SHALL have port syndrome, output, WIDTH, in_a XOR in_b of the first mismatching sample of the current episode.
REQ-015 SHALL have port state, output, 2, FSM state encoding OK=00, SUSPECT=01, ALARM=10.

Function
REQ-016 A sample SHALL be compared only in cycles where enable=1 and valid=1; all other cycles leave every register unchanged except that mismatch is driven to 0.
REQ-017 mismatch SHALL be 1 in the cycle after a compared sample with in_a != in_b, else 0 (one-cycle latency).
REQ-018 Internal run counter SHALL count consecutive compared mismatches; non-compared cycles neither increment nor reset it.
REQ-019 OK: compared mismatch -> SUSPECT with run=1, syndrome captured; if THRESHOLD=1 -> ALARM directly. Compared match stays OK.
REQ-020 SUSPECT: compared mismatch increments run; when run reaches THRESHOLD -> ALARM. Compared match -> OK with run=0; syndrome held.
REQ-021 ALARM SHALL hold until clear or reset; compared samples in ALARM change only mismatch and fault_count.
REQ-022 alarm SHALL equal 1 exactly when state=ALARM, asserting the cycle after the THRESHOLD-th consecutive mismatching sample.
REQ-023 syndrome SHALL be captured only on the OK-to-SUSPECT/ALARM transition and held until clear or reset.
REQ-024 fault_count SHALL increment on every compared mismatch in any state and saturate at all-ones; clear does not affect it.
REQ-025 clear SHALL, in any state, set state=OK, run=0, syndrome=0 next cycle; clear takes priority over a simultaneous compared sample, which is ignored for FSM/run/syndrome but still updates mismatch and fault_count.

Reset
REQ-026 reset=1 SHALL, at the next rising edge, set state=OK, run=0, mismatch=0, alarm=0, fault_count=0, syndrome=0, with priority over clear and all sample inputs.
REQ-027 reset asserted mid-episode (SUSPECT or ALARM) SHALL discard the episode completely.

Verification (WIDTH=8, THRESHOLD=3, CNT_W=8 unless stated)
REQ-028 in_a=in_b=0xAA, valid=enable=1 for 20 cycles -> mismatch=0, alarm=0, fault_count=0, state=OK throughout.
REQ-029 Two samples in_a=0xAB/in_b=0xAA then matching -> mismatch high 2 cycles, state OK->SUSPECT->OK, syndrome=0x01, fault_count=2, alarm=0.
REQ-030 Three consecutive samples in_a=0xFF/in_b=0xAA, with valid=0 gaps between them -> alarm=1 the cycle after the third, syndrome=0x55, fault_count=3; alarm stays 1 through subsequent matching samples.
REQ-031 In ALARM, clear=1 coincident with a mismatching sample -> next cycle alarm=0, state=OK, syndrome=0, mismatch=1, fault_count incremented by 1.
REQ-032 CNT_W=2, five consecutive mismatches -> fault_count sticks at 3; enable=0 with mismatching samples -> no mismatch pulse, no count change.
REQ-033 reset asserted in SUSPECT (run=2) -> all outputs 0 next cycle; a following single mismatch does not raise alarm.

Source files
------------

// File: rtl/lockstep_fault_detector.sv
// Lockstep comparator: flags per-sample divergence between core A and core B,
// tracks consecutive-mismatch episodes and raises a sticky alarm once the run
// of mismatches reaches THRESHOLD.
module lockstep_fault_detector #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned THRESHOLD = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             clear,
    output logic             mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] fault_count,
    output logic [WIDTH-1:0] syndrome,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StOk      = 2'b00,
        StSuspect = 2'b01,
        StAlarm   = 2'b10
    } state_e;

    // Run counter is wide enough for the largest legal threshold (255).
    localparam logic [7:0] THR = 8'(THRESHOLD);

    state_e           r_state;
    logic [7:0]       r_run;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_fault_count;
    logic [WIDTH-1:0] r_syndrome;

    logic             w_cmp;
    logic [WIDTH-1:0] w_xor;
    logic             w_fault;
    logic [7:0]       w_run_inc;

    assign w_cmp     = enable & valid;
    assign w_xor     = in_a ^ in_b;
    assign w_fault   = w_cmp & (|w_xor);
    assign w_run_inc = r_run + 8'd1;

    // Episode FSM, run counter, syndrome capture, mismatch flag and fault count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StOk;
            r_run         <= 8'd0;
            r_mismatch    <= 1'b0;
            r_fault_count <= '0;
            r_syndrome    <= '0;
        end else begin
            r_mismatch <= w_fault;
            // Total count ignores clear and saturates at all-ones.
            if (w_fault && (r_fault_count != {CNT_W{1'b1}})) begin
                r_fault_count <= r_fault_count + 1'b1;
            end

            if (clear) begin
                // A coincident sample is dropped for episode tracking.
                r_state    <= StOk;
                r_run      <= 8'd0;
                r_syndrome <= '0;
            end else if (w_cmp) begin
                unique case (r_state)
                    StOk: begin
                        if (w_fault) begin
                            r_syndrome <= w_xor;
                            r_run      <= 8'd1;
                            r_state    <= (THR == 8'd1) ? StAlarm : StSuspect;
                        end
                    end
                    StSuspect: begin
                        if (w_fault) begin
                            r_run <= w_run_inc;
                            if (w_run_inc == THR) begin
                                r_state <= StAlarm;
                            end
                        end else begin
                            // Syndrome of the broken episode is kept until clear.
                            r_run   <= 8'd0;
                            r_state <= StOk;
                        end
                    end
                    StAlarm: begin
                        // Sticky until clear or reset.
                    end
                    default: begin
                        r_state <= StOk;
                        r_run   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign mismatch    = r_mismatch;
    assign alarm       = (r_state == StAlarm);
    assign fault_count = r_fault_count;
    assign syndrome    = r_syndrome;
    assign state       = r_state;

endmodule

// File: tb/tb_lockstep_fault_detector.sv
// Directed bench for lockstep_fault_detector: a default instance, a CNT_W=2
// instance for saturation and a THRESHOLD=1 instance, all on shared inputs.
module tb_lockstep_fault_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       clear;

    logic       mism, alrm;
    logic [7:0] cnt, synd;
    logic [1:0] st;

    logic       mism2, alrm2;
    logic [1:0] cnt2;
    logic [7:0] synd2;
    logic [1:0] st2;

    logic       mism1, alrm1;
    logic [7:0] cnt1, synd1;
    logic [1:0] st1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lockstep_fault_detector #(.WIDTH(8), .THRESHOLD(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .valid(valid),
        .in_a(in_a), .in_b(in_b), .clear(clear),
        .mismatch(mism), .alarm(alrm), .fault_count(cnt),
        .syndrome(synd), .state(st)
    );

    lockstep_fault_detector #(.WIDTH(8), .THRESHOLD(3), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .valid(valid),
        .in_a(in_a), .in_b(in_b), .clear(clear),
        .mismatch(mism2), .alarm(alrm2), .fault_count(cnt2),
        .syndrome(synd2), .state(st2)
    );

    lockstep_fault_detector #(.WIDTH(8), .THRESHOLD(1), .CNT_W(8)) dut_t1 (
        .clk(clk), .reset(reset), .enable(enable), .valid(valid),
        .in_a(in_a), .in_b(in_b), .clear(clear),
        .mismatch(mism1), .alarm(alrm1), .fault_count(cnt1),
        .syndrome(synd1), .state(st1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are looked at 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        valid = v;
        in_a  = a;
        in_b  = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        clear  = 1'b0;
        drive(1'b1, 8'hFF, 8'h00);

        // Reset has priority over a mismatching sample.
        step();
        check_eq("rst_state", st, 2'b00);
        check_eq("rst_mism", mism, 1'b0);
        check_eq("rst_alarm", alrm, 1'b0);
        check_eq("rst_cnt", cnt, 8'd0);
        check_eq("rst_synd", synd, 8'd0);
        reset = 1'b0;

        // Long matching stream.
        drive(1'b1, 8'hAA, 8'hAA);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("match_mism", mism, 1'b0);
            check_eq("match_alarm", alrm, 1'b0);
            check_eq("match_cnt", cnt, 8'd0);
            check_eq("match_state", st, 2'b00);
        end

        // Two-sample episode that recovers.
        drive(1'b1, 8'hAB, 8'hAA);
        step();
        check_eq("ep_mism1", mism, 1'b1);
        check_eq("ep_state1", st, 2'b01);
        check_eq("ep_synd1", synd, 8'h01);
        check_eq("ep_cnt1", cnt, 8'd1);
        check_eq("t1_alarm", alrm1, 1'b1);
        check_eq("t1_state", st1, 2'b10);
        drive(1'b1, 8'hAB, 8'hAA);
        step();
        check_eq("ep_mism2", mism, 1'b1);
        check_eq("ep_state2", st, 2'b01);
        check_eq("ep_cnt2", cnt, 8'd2);
        drive(1'b1, 8'hAA, 8'hAA);
        step();
        check_eq("ep_mism3", mism, 1'b0);
        check_eq("ep_state3", st, 2'b00);
        check_eq("ep_synd3", synd, 8'h01);
        check_eq("ep_cnt3", cnt, 8'd2);
        check_eq("ep_alarm3", alrm, 1'b0);

        // Three mismatches separated by valid=0 gaps reach the alarm.
        do_reset();
        drive(1'b1, 8'hFF, 8'hAA);
        step();
        check_eq("gap_state1", st, 2'b01);
        drive(1'b0, 8'hFF, 8'hAA);
        step();
        check_eq("gap_mism_idle", mism, 1'b0);
        check_eq("gap_state_idle", st, 2'b01);
        drive(1'b1, 8'hFF, 8'hAA);
        step();
        check_eq("gap_state2", st, 2'b01);
        check_eq("gap_alarm2", alrm, 1'b0);
        drive(1'b0, 8'hFF, 8'hAA);
        step();
        check_eq("gap_cnt_idle", cnt, 8'd2);
        drive(1'b1, 8'hFF, 8'hAA);
        step();
        check_eq("gap_alarm3", alrm, 1'b1);
        check_eq("gap_state3", st, 2'b10);
        check_eq("gap_synd3", synd, 8'h55);
        check_eq("gap_cnt3", cnt, 8'd3);
        drive(1'b1, 8'hAA, 8'hAA);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("sticky_alarm", alrm, 1'b1);
            check_eq("sticky_mism", mism, 1'b0);
            check_eq("sticky_cnt", cnt, 8'd3);
        end

        // Clear wins over a coincident mismatching sample.
        clear = 1'b1;
        drive(1'b1, 8'hFF, 8'hAA);
        step();
        clear = 1'b0;
        check_eq("clr_alarm", alrm, 1'b0);
        check_eq("clr_state", st, 2'b00);
        check_eq("clr_synd", synd, 8'h00);
        check_eq("clr_mism", mism, 1'b1);
        check_eq("clr_cnt", cnt, 8'd4);
        drive(1'b1, 8'hAA, 8'hAA);
        step();
        check_eq("clr_after_state", st, 2'b00);

        // Saturation on the 2-bit counter, then enable=0 blocks comparison.
        do_reset();
        drive(1'b1, 8'h0F, 8'hF0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("sat_cnt2", cnt2, (i > 3) ? 2'd3 : 2'(i));
        end
        check_eq("sat_cnt8", cnt, 8'd5);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("dis_mism", mism, 1'b0);
            check_eq("dis_cnt2", cnt2, 2'd3);
            check_eq("dis_cnt8", cnt, 8'd5);
        end
        enable = 1'b1;

        // Reset mid-episode discards it.
        do_reset();
        drive(1'b1, 8'h12, 8'h34);
        step();
        step();
        check_eq("mid_state", st, 2'b01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_state", st, 2'b00);
        check_eq("mid_rst_mism", mism, 1'b0);
        check_eq("mid_rst_alarm", alrm, 1'b0);
        check_eq("mid_rst_cnt", cnt, 8'd0);
        check_eq("mid_rst_synd", synd, 8'd0);
        step();
        check_eq("post_state", st, 2'b01);
        check_eq("post_alarm", alrm, 1'b0);
        check_eq("post_cnt", cnt, 8'd1);
        check_eq("post_synd", synd, 8'h26);
        drive(1'b1, 8'h34, 8'h34);
        step();
        check_eq("post_ok", st, 2'b00);
        check_eq("post_alarm2", alrm, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
